// File: rtl/common_defs_pkg.sv
// rtl/common_defs_pkg.sv - shared Path ORAM geometry, tuple/bucket types and helpers
// Contents: tree geometry, oram_tuple_t, oram_bucket_t, path writer FSM states,
// node_addr() heap address of the path node at a given level.
package common_defs_pkg;

   localparam int TREE_DEPTH = 12;
   localparam int K          = 3;
   localparam int ALPHA      = 4;
   localparam int BYTE_WIDTH = 8;

   // {valid, block_id, leaf, data}; valid is the MSB
   typedef struct packed {
      logic                  valid;
      logic [11:0]           block_id;
      logic [TREE_DEPTH-1:0] leaf;
      logic [31:0]           data;
   } oram_tuple_t;

   localparam int TUPLE_W     = $bits(oram_tuple_t);
   localparam int NODE_ADDR_W = TREE_DEPTH + 1;
   localparam int BUCKET_W    = K * TUPLE_W;
   localparam int LEVEL_W     = $clog2(TREE_DEPTH + 1);

   // slot 0 sits in the LSBs
   typedef oram_tuple_t [K-1:0] oram_bucket_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } pw_state_t;

   // Heap index of the node at depth 'level' on the path to 'leaf'
   function automatic logic [NODE_ADDR_W-1:0] node_addr(
      input logic [TREE_DEPTH-1:0] leaf,
      input logic [LEVEL_W-1:0]    level
   );
      logic [NODE_ADDR_W-1:0] base;
      logic [NODE_ADDR_W-1:0] off;
      base = (NODE_ADDR_W'(1) << level) - NODE_ADDR_W'(1);
      off  = NODE_ADDR_W'(leaf >> (LEVEL_W'(TREE_DEPTH) - level));
      return base + off;
   endfunction

endpackage

// File: rtl/oram_prefix_match.sv
// rtl/oram_prefix_match.sv - leaf/path prefix match for bucket eligibility
// Ports: tuple_leaf, path_leaf, level in; eligible out (combinational).
// eligible is high when the top 'level' bits of both leaves agree, so the
// tuple may live in the path node at that level; always high at the root.
module oram_prefix_match
   import common_defs_pkg::*;
(
   input  logic [TREE_DEPTH-1:0] tuple_leaf,
   input  logic [TREE_DEPTH-1:0] path_leaf,
   input  logic [LEVEL_W-1:0]    level,
   output logic                  eligible
);

   logic [TREE_DEPTH-1:0] diff;
   logic [LEVEL_W-1:0]    shamt;

   assign diff     = tuple_leaf ^ path_leaf;
   assign shamt    = LEVEL_W'(TREE_DEPTH) - level;
   assign eligible = ((diff >> shamt) == '0);

endmodule

// File: rtl/oram_path_writer.sv
// rtl/oram_path_writer.sv - Path ORAM write-back: evicts stash tuples onto a path, leaf to root
// Ports: clk, rst_n (async active-low); start/path_leaf command; busy/done status;
// stash_idx/stash_tuple/stash_clr stash read+invalidate; mem_wr_valid/ready/addr/bucket
// bucket write request, one per tree level.
module oram_path_writer
   import common_defs_pkg::*;
#(
   parameter int STASH_SIZE = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [TREE_DEPTH-1:0]         path_leaf,
   output logic                          busy,
   output logic                          done,
   output logic [$clog2(STASH_SIZE)-1:0] stash_idx,
   input  logic [TUPLE_W-1:0]            stash_tuple,
   output logic                          stash_clr,
   output logic                          mem_wr_valid,
   input  logic                          mem_wr_ready,
   output logic [NODE_ADDR_W-1:0]        mem_wr_addr,
   output logic [BUCKET_W-1:0]           mem_wr_bucket
);

   localparam int IDX_W  = $clog2(STASH_SIZE);
   localparam int FILL_W = $clog2(K + 1);

   pw_state_t             state_q;
   logic [TREE_DEPTH-1:0] leaf_q;
   logic [LEVEL_W-1:0]    level_q;
   logic [IDX_W-1:0]      idx_q;
   logic [FILL_W-1:0]     fill_q;
   oram_bucket_t          slots_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  wr_valid_q;
   logic [NODE_ADDR_W-1:0] wr_addr_q;

   oram_tuple_t cur;
   logic        prefix_ok;
   logic        scan_hit;
   logic        scan_last;

   assign cur = stash_tuple;

   oram_prefix_match u_match (
      .tuple_leaf (cur.leaf),
      .path_leaf  (leaf_q),
      .level      (level_q),
      .eligible   (prefix_ok)
   );

   // The clear has to land in the same cycle as the read; the stash applies
   // it at the next edge, so the entry is already invalid on the next scan.
   assign scan_hit  = (state_q == SCAN) && cur.valid && prefix_ok;
   assign scan_last = (scan_hit && (fill_q == FILL_W'(K - 1))) ||
                      (idx_q == IDX_W'(STASH_SIZE - 1));

   assign busy          = busy_q;
   assign done          = done_q;
   assign stash_idx     = idx_q;
   assign stash_clr     = scan_hit;
   assign mem_wr_valid  = wr_valid_q;
   assign mem_wr_addr   = wr_addr_q;
   // slots fill up during SCAN; only expose them while the write is pending
   assign mem_wr_bucket = wr_valid_q ? slots_q : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         leaf_q     <= '0;
         level_q    <= '0;
         idx_q      <= '0;
         fill_q     <= '0;
         slots_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  leaf_q  <= path_leaf;
                  level_q <= LEVEL_W'(TREE_DEPTH);
                  slots_q <= '0;
                  fill_q  <= '0;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SCAN;
               end
            end

            SCAN: begin
               if (scan_hit) begin
                  slots_q[fill_q] <= cur;
                  fill_q          <= fill_q + FILL_W'(1);
               end
               if (scan_last) begin
                  idx_q      <= '0;
                  wr_valid_q <= 1'b1;
                  wr_addr_q  <= node_addr(leaf_q, level_q);
                  state_q    <= WRITE;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end

            WRITE: begin
               if (mem_wr_ready) begin
                  wr_valid_q <= 1'b0;
                  wr_addr_q  <= '0;
                  slots_q    <= '0;
                  fill_q     <= '0;
                  if (level_q == '0) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     level_q <= level_q - LEVEL_W'(1);
                     state_q <= SCAN;
                  end
               end
            end

            DONE: begin
               // start is not looked at here, so a start coinciding with done is dropped
               done_q  <= 1'b0;
               state_q <= IDLE;
            end

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_oram_path_writer.sv
// tb/tb_oram_path_writer.sv - self-checking bench for oram_path_writer
module tb_oram_path_writer;
   import common_defs_pkg::*;

   localparam int SS = 16;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   start;
   logic [TREE_DEPTH-1:0]  path_leaf;
   logic                   busy;
   logic                   done;
   logic [3:0]             stash_idx;
   logic [TUPLE_W-1:0]     stash_tuple;
   logic                   stash_clr;
   logic                   mem_wr_valid;
   logic                   mem_wr_ready;
   logic [NODE_ADDR_W-1:0] mem_wr_addr;
   logic [BUCKET_W-1:0]    mem_wr_bucket;

   oram_tuple_t stash [SS];

   int n_tests = 0;
   int n_fail  = 0;

   logic [NODE_ADDR_W-1:0] oa [$];
   logic [BUCKET_W-1:0]    ob [$];
   int                     oc [$];

   always #5 clk = ~clk;

   assign stash_tuple = stash[stash_idx];

   oram_path_writer #(.STASH_SIZE(SS)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .path_leaf     (path_leaf),
      .busy          (busy),
      .done          (done),
      .stash_idx     (stash_idx),
      .stash_tuple   (stash_tuple),
      .stash_clr     (stash_clr),
      .mem_wr_valid  (mem_wr_valid),
      .mem_wr_ready  (mem_wr_ready),
      .mem_wr_addr   (mem_wr_addr),
      .mem_wr_bucket (mem_wr_bucket)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic oram_tuple_t mk(input logic v, input logic [11:0] id,
                                      input logic [11:0] lf, input logic [31:0] d);
      oram_tuple_t t;
      t.valid = v; t.block_id = id; t.leaf = lf; t.data = d;
      return t;
   endfunction

   function automatic logic [191:0] outs();
      return {busy, done, stash_idx, stash_clr, mem_wr_valid, mem_wr_addr, mem_wr_bucket};
   endfunction

   task automatic clear_stash();
      for (int i = 0; i < SS; i++) stash[i] = '0;
   endtask

   // One write-back pass against a greedy leaf-to-root eviction model.
   // stall_n: first WRITE sees ready low this many cycles; glitch_cyc: pulse
   // start with another leaf mid-run; abort_cyc: assert reset at that cycle.
   task automatic run_pass(input logic [11:0] path, input int stall_n, input int glitch_cyc,
                           input int abort_cyc, input bit rand_ready, output int done_cyc);
      oram_tuple_t            ms [SS];
      logic [NODE_ADDR_W-1:0] ea [$];
      logic [BUCKET_W-1:0]    eb [$];
      int                     ec [$];
      int  exp_cycles, stall_cnt, busy_err, stab_err, clr_i, bad;
      bit  clr_pend, held, got_done;
      logic [NODE_ADDR_W-1:0] hold_a;
      logic [BUCKET_W-1:0]    hold_b;
      logic [15:0]            exp_left, got_left;

      // reference model
      for (int i = 0; i < SS; i++) ms[i] = stash[i];
      exp_cycles = 1;
      for (int l = TREE_DEPTH; l >= 0; l--) begin
         logic [BUCKET_W-1:0] b;
         int cnt, scanned;
         b = '0; cnt = 0; scanned = SS;
         for (int i = 0; i < SS; i++) begin
            if (ms[i].valid && ((ms[i].leaf >> (TREE_DEPTH - l)) == (path >> (TREE_DEPTH - l)))) begin
               b[cnt*TUPLE_W +: TUPLE_W] = ms[i];
               ec.push_back(i);
               ms[i] = '0;
               cnt++;
               if (cnt == K) begin
                  scanned = i + 1;
                  break;
               end
            end
         end
         exp_cycles += scanned + 1;
         ea.push_back(NODE_ADDR_W'((1 << l) - 1 + (path >> (TREE_DEPTH - l))));
         eb.push_back(b);
      end

      oa.delete(); ob.delete(); oc.delete();
      stall_cnt = 0; busy_err = 0; stab_err = 0; clr_pend = 0; held = 0; got_done = 0;
      clr_i = 0; done_cyc = 0; hold_a = '0; hold_b = '0;

      @(posedge clk); #1;
      start = 1'b1; path_leaf = path;
      mem_wr_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;

      for (int cyc = 1; cyc <= 3000; cyc++) begin
         if (cyc > 1) begin @(posedge clk); #1; end
         if (clr_pend) begin stash[clr_i] = '0; clr_pend = 0; end
         start     = (cyc == glitch_cyc);
         path_leaf = start ? ~path : path;
         if (rand_ready)      mem_wr_ready = ($urandom_range(0, 3) != 0);
         else if (stall_n > 0) mem_wr_ready = (stall_cnt >= stall_n);
         else                 mem_wr_ready = 1'b1;
         if (cyc == abort_cyc) begin
            rst_n = 1'b0;
            #1;
            chk("rst_async_outs", outs(), '0);
            bad = 0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               if (done || mem_wr_valid || stash_clr || busy) bad++;
            end
            chk("rst_quiet", bad, 0);
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         @(negedge clk);
         if (done) begin
            if (busy) busy_err++;
         end else if (!busy) busy_err++;
         if (mem_wr_valid) begin
            if (!held) begin
               hold_a = mem_wr_addr; hold_b = mem_wr_bucket; held = 1;
            end else if (mem_wr_addr !== hold_a || mem_wr_bucket !== hold_b) stab_err++;
            if (mem_wr_ready) begin
               oa.push_back(mem_wr_addr); ob.push_back(mem_wr_bucket); held = 0;
            end else stall_cnt++;
         end
         if (stash_clr) begin
            oc.push_back(int'(stash_idx)); clr_pend = 1; clr_i = int'(stash_idx);
         end
         if (done) begin
            got_done = 1; done_cyc = cyc;
            break;
         end
      end
      chk("done_seen", got_done, 1'b1);
      if (clr_pend) stash[clr_i] = '0;

      @(posedge clk); #1;
      @(negedge clk);
      chk("done_pulse_1cyc", {done, busy}, 2'b00);

      chk("done_cycle", done_cyc, exp_cycles + stall_cnt);
      chk("busy_window", busy_err, 0);
      chk("wr_stable", stab_err, 0);
      chk("n_writes", oa.size(), ea.size());
      for (int i = 0; i < ea.size(); i++) begin
         chk($sformatf("wr_addr[%0d]", i), oa[i], ea[i]);
         chk($sformatf("wr_bucket[%0d]", i), ob[i], eb[i]);
      end
      chk("n_clr", oc.size(), ec.size());
      for (int i = 0; i < ec.size(); i++) chk($sformatf("clr_idx[%0d]", i), oc[i], ec[i]);
      for (int i = 0; i < SS; i++) begin
         exp_left[i] = ms[i].valid;
         got_left[i] = stash[i].valid;
      end
      chk("stash_left", got_left, exp_left);
   endtask

   initial begin
      int dc;
      oram_tuple_t t0, t3, t5;
      logic [11:0] p;

      rst_n = 1'b0; start = 1'b0; path_leaf = '0; mem_wr_ready = 1'b0;
      clear_stash();
      #12;
      chk("reset_outs", outs(), '0);
      @(negedge clk);
      rst_n = 1'b1;

      // empty stash, path 0
      run_pass(12'h000, 0, 0, 0, 0, dc);
      chk("empty_done_222", dc, 222);
      chk("empty_first_addr", oa[0], 4095);
      chk("empty_root_addr", oa[12], 0);

      // four entries on leaf 0xABC
      clear_stash();
      for (int i = 0; i < 4; i++) stash[i] = mk(1'b1, 12'(i + 1), 12'hABC, 32'hD000_0000 + i);
      t0 = stash[0]; t3 = stash[3];
      run_pass(12'hABC, 0, 0, 0, 0, dc);
      chk("abc_addr0", oa[0], 6843);
      chk("abc_slot0", ob[0][TUPLE_W-1:0], t0);
      chk("abc_addr1", oa[1], 3421);
      chk("abc_l11_slot0", ob[1][TUPLE_W-1:0], t3);

      // entry 5 only fits the root
      clear_stash();
      stash[5] = mk(1'b1, 12'h055, 12'h800, 32'hCAFE_F00D);
      t5 = stash[5];
      run_pass(12'h000, 0, 0, 0, 0, dc);
      chk("root_only_bucket", ob[12][TUPLE_W-1:0], t5);
      chk("root_only_clr", {oc.size(), oc[0]}, {32'd1, 32'd5});

      // ready low for 5 cycles on the first write
      clear_stash();
      run_pass(12'h000, 5, 0, 0, 0, dc);
      chk("stall_done_227", dc, 227);

      // start pulsed while busy
      clear_stash();
      for (int i = 0; i < SS; i += 2) stash[i] = mk(1'b1, 12'(i), 12'h3C5 ^ 12'(i), $urandom);
      run_pass(12'h3C5, 0, 40, 0, 0, dc);

      // reset mid-SCAN, then a full pass
      clear_stash();
      run_pass(12'h123, 0, 0, 30, 0, dc);
      for (int i = 0; i < SS; i++) stash[i] = mk(1'b1, 12'(i), 12'h123 ^ 12'(i * 37), $urandom);
      run_pass(12'h123, 0, 0, 0, 0, dc);

      // randomized stash contents and ready
      for (int r = 0; r < 6; r++) begin
         p = 12'($urandom);
         for (int i = 0; i < SS; i++) begin
            logic [11:0] mask;
            mask = 12'((1 << $urandom_range(0, 12)) - 1);
            stash[i] = mk(1'($urandom_range(0, 1)), 12'($urandom), p ^ (12'($urandom) & mask), $urandom);
         end
         run_pass(p, 0, 0, 0, r[0], dc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
